// File: rtl/isa_io_cycle_sequencer_if.sv
// Requester handshake plus ISA riser pin bundle for isa_io_cycle_sequencer.
// master = requester/pin side, slave = the sequencer itself.
interface isa_io_cycle_sequencer_if;
  logic        req;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        ready;
  logic        done;
  logic [15:0] rdata;
  logic        timeout;
  logic [15:0] addr_out;
  logic [15:0] d_out;
  logic [15:0] d_in;
  logic        d_oe;
  logic        ior_n;
  logic        iow_n;
  logic        aen;
  logic        iochrdy;

  modport master (
    output req, req_we, req_addr, req_wdata, d_in, iochrdy,
    input  ready, done, rdata, timeout, addr_out, d_out, d_oe, ior_n, iow_n, aen
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, d_in, iochrdy,
    output ready, done, rdata, timeout, addr_out, d_out, d_oe, ior_n, iow_n, aen
  );
endinterface

// File: rtl/isa_io_cycle_sequencer.sv
// Sequences one ISA I/O read or write (setup / strobe / hold) per accepted request.
// Define ISA_IOCHRDY_EN to let IOCHRDY stretch the strobe, with a timeout abort.
module isa_io_cycle_sequencer #(
  parameter int SETUP_CYC   = 4,
  parameter int STROBE_CYC  = 25,
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT_CYC = 800
) (
  input  logic                      clk_50MHz,
  input  logic                      reset,
  isa_io_cycle_sequencer_if.slave   bus
);

  localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_HT  = (HOLD_CYC > TIMEOUT_CYC) ? HOLD_CYC : TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_SS > MAX_HT) ? MAX_SS : MAX_HT;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam cnt_t SETUP_LD  = cnt_t'(SETUP_CYC);
  localparam cnt_t STROBE_LD = cnt_t'(STROBE_CYC);
  localparam cnt_t HOLD_LD   = cnt_t'(HOLD_CYC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  state_t      r_state, w_state;
  cnt_t        r_cnt, w_cnt;
  logic        r_we, w_we;
  logic        r_ready, w_ready;
  logic        r_done, w_done;
  logic        r_ior_n, w_ior_n;
  logic        r_iow_n, w_iow_n;
  logic        r_aen, w_aen;
  logic        r_d_oe, w_d_oe;
  logic [15:0] r_addr, w_addr;
  logic [15:0] r_dout, w_dout;
  logic [15:0] r_rdata, w_rdata;
  logic        w_release;
  logic        w_abort;

`ifdef ISA_IOCHRDY_EN
  localparam cnt_t TIMEOUT_LD = cnt_t'(TIMEOUT_CYC);
  logic r_ext, w_ext;
  cnt_t r_wait, w_wait;
  logic r_to_flag, w_to_flag;
  logic r_timeout, w_timeout;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_we      = r_we;
    w_ready   = r_ready;
    w_done    = 1'b0;
    w_ior_n   = r_ior_n;
    w_iow_n   = r_iow_n;
    w_aen     = r_aen;
    w_d_oe    = r_d_oe;
    w_addr    = r_addr;
    w_dout    = r_dout;
    w_rdata   = r_rdata;
    w_release = 1'b0;
    w_abort   = 1'b0;
`ifdef ISA_IOCHRDY_EN
    w_ext     = r_ext;
    w_wait    = r_wait;
    w_to_flag = r_to_flag;
    w_timeout = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          w_we    = bus.req_we;
          w_addr  = bus.req_addr;
          w_dout  = bus.req_wdata;
          w_d_oe  = bus.req_we;
          w_aen   = 1'b0;
          w_ready = 1'b0;
          w_cnt   = SETUP_LD;
          w_state = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (r_cnt == CNT_ONE) begin
          // Only one strobe is ever selected, keyed off the latched direction.
          if (r_we) w_iow_n = 1'b0;
          else      w_ior_n = 1'b0;
          w_cnt   = STROBE_LD;
          w_state = ST_STROBE;
        end else begin
          w_cnt = r_cnt - CNT_ONE;
        end
      end

      ST_STROBE: begin
`ifdef ISA_IOCHRDY_EN
        if (r_ext) begin
          if (bus.iochrdy)           w_release = 1'b1;
          else if (r_wait == CNT_ONE) w_abort   = 1'b1;
          else                       w_wait    = r_wait - CNT_ONE;
        end else if (r_cnt == CNT_ONE) begin
          if (bus.iochrdy) begin
            w_release = 1'b1;
          end else begin
            w_ext  = 1'b1;
            w_wait = TIMEOUT_LD;
          end
        end else begin
          w_cnt = r_cnt - CNT_ONE;
        end
`else
        if (r_cnt == CNT_ONE) w_release = 1'b1;
        else                  w_cnt     = r_cnt - CNT_ONE;
`endif
        if (w_release || w_abort) begin
          // Read data is taken on the same edge the strobe releases.
          if (!r_we) w_rdata = w_abort ? 16'hFFFF : bus.d_in;
          w_ior_n = 1'b1;
          w_iow_n = 1'b1;
          w_cnt   = HOLD_LD;
          w_state = ST_HOLD;
`ifdef ISA_IOCHRDY_EN
          w_ext     = 1'b0;
          w_to_flag = w_abort;
`endif
        end
      end

      ST_HOLD: begin
        if (r_cnt == CNT_ONE) begin
          w_aen   = 1'b1;
          w_d_oe  = 1'b0;
          w_done  = 1'b1;
          w_ready = 1'b1;
          w_state = ST_IDLE;
`ifdef ISA_IOCHRDY_EN
          w_timeout = r_to_flag;
          w_to_flag = 1'b0;
`endif
        end else begin
          w_cnt = r_cnt - CNT_ONE;
        end
      end

      default: w_state = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values computed above.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_ior_n <= 1'b1;
      r_iow_n <= 1'b1;
      r_aen   <= 1'b1;
      r_d_oe  <= 1'b0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_rdata <= '0;
`ifdef ISA_IOCHRDY_EN
      r_ext     <= 1'b0;
      r_wait    <= '0;
      r_to_flag <= 1'b0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_we    <= w_we;
      r_ready <= w_ready;
      r_done  <= w_done;
      r_ior_n <= w_ior_n;
      r_iow_n <= w_iow_n;
      r_aen   <= w_aen;
      r_d_oe  <= w_d_oe;
      r_addr  <= w_addr;
      r_dout  <= w_dout;
      r_rdata <= w_rdata;
`ifdef ISA_IOCHRDY_EN
      r_ext     <= w_ext;
      r_wait    <= w_wait;
      r_to_flag <= w_to_flag;
      r_timeout <= w_timeout;
`endif
    end
  end

  assign bus.ready    = r_ready;
  assign bus.done     = r_done;
  assign bus.rdata    = r_rdata;
  assign bus.addr_out = r_addr;
  assign bus.d_out    = r_dout;
  assign bus.d_oe     = r_d_oe;
  assign bus.ior_n    = r_ior_n;
  assign bus.iow_n    = r_iow_n;
  assign bus.aen      = r_aen;

`ifdef ISA_IOCHRDY_EN
  assign bus.timeout = r_timeout;
`else
  // Fixed timing: IOCHRDY has no effect and no cycle can time out.
  assign bus.timeout = 1'b0;
  wire w_unused = bus.iochrdy;
`endif

endmodule
